alarm_clock_timekeeper: RTL
===========================

// Module: alarm_clock_timekeeper
// PURPOSE
//   24-hour BCD timekeeper with one programmable alarm, sitting directly upstream of the
//   tt_um top/display stage. Divides clk to a 1 Hz tick and keeps HH:MM:SS. Lets the user
//   set time or alarm with single-cycle increment pulses. Raises alarm_ringing on match.
//   All outputs are registered BCD; the downstream stage only maps them onto pins.
// PARAMETERS
//   CLK_HZ     10_000_000  clk cycles per second; prescaler terminal count = CLK_HZ-1 (>=2)
//   RING_SECS  60          seconds alarm_ringing stays high unless dismissed (1..255)
// PORTS
//   clk            in   1  system clock
//   rst_n          in   1  asynchronous, active-low reset
//   set_mode       in   2  00=run, 01=set time, 10=set alarm, 11=run
//   inc_hr_p       in   1  one-cycle pulse: increment hours of selected target
//   inc_min_p      in   1  one-cycle pulse: increment minutes of selected target
//   alarm_en       in   1  level: alarm armed
//   dismiss_p      in   1  one-cycle pulse: stop ringing
//   time_hh_bcd    out  8  hours   {tens,units} 00..23
//   time_mm_bcd    out  8  minutes 00..59
//   time_ss_bcd    out  8  seconds 00..59
//   alarm_hh_bcd   out  8  alarm hours
//   alarm_mm_bcd   out  8  alarm minutes
//   tick_1hz       out  1  one-cycle pulse per second (run mode only)
//   alarm_ringing  out  1  level: alarm active
// BEHAVIOUR
//   Reset (async, rst_n=0): time 00:00:00, alarm 06:00 (0x06,0x00), prescaler 0,
//     tick_1hz=0, alarm_ringing=0, ring counter 0. Release is synchronised by the caller.
//   Prescaler counts 0..CLK_HZ-1 and wraps. tick_1hz is registered and is high for exactly one
//     cycle when the count wraps. The time update happens in that cycle and is visible next cycle.
//   Run (00/11), on tick: ss+1. 59->00 carries to mm. mm 59->00 carries to hh.
//     23:59:59 -> 00:00:00. Increment pulses are ignored.
//   Set time (01): prescaler and ss held at 0, tick_1hz=0. inc_min_p: mm+1 mod 60, no carry.
//     inc_hr_p: hh+1 mod 24. Both pulses in one cycle: both apply.
//     On leaving 01, counting restarts from prescaler 0, so the first tick comes CLK_HZ cycles later.
//   Set alarm (10): time keeps running. Pulses act on the alarm registers mod 60 / mod 24.
//   Match: in the cycle after a tick, if alarm_en=1, set_mode!=01, time==alarm HH:MM and ss==00,
//     then alarm_ringing<=1 and ring counter<=0.
//   While ringing, each tick increments the ring counter. At RING_SECS ticks, ringing<=0.
//   ringing<=0 on dismiss_p, on alarm_en=0, or on entry to set-time mode.
//     The clear wins over a match in the same cycle.
//   Reset mid-operation: all state returns to reset values immediately. No partial update.
//   BCD digits never hold illegal codes (>9, hours >23) in any reachable state.
// STRUCTURE
//   Package alarm_clock_pkg: mode_t enum (MODE_RUN, MODE_SET_TIME, MODE_SET_ALARM),
//     BCD limits (SEC_MAX=8'h59, MIN_MAX=8'h59, HR_MAX=8'h23), ALARM_RST_HH=8'h06.
//   Sub-module bcd_mod_counter #(MAX_BCD): 8-bit BCD register with inc, clr and carry_out.
//     Carry_out fires when inc is applied at MAX_BCD. Instantiated 5x: ss, mm, hh, alarm mm,
//     alarm hh. Prescaler, ring counter and match logic stay in this module.
// TESTING  (CLK_HZ=4, RING_SECS=3 for simulation)
//   1. Reset, then run 4 cycles: tick_1hz pulses once, then time_ss_bcd=0x01. No ringing.
//   2. Preload 23:59:59 via set mode, return to run, one tick: time reads 0x00,0x00,0x00.
//   3. Mode 01, pulse inc_min_p 61x and inc_hr_p 25x (some in the same cycle): mm=0x01, hh=0x01.
//      ss=0x00 and tick_1hz stays 0 throughout.
//   4. Alarm 00:01, alarm_en=1, run from 00:00:59: ringing=1 one cycle after the tick.
//      Drops after 3 ticks.
//   5. Ringing, then dismiss_p: ringing=0 next cycle. Repeat with alarm_en=0 and with mode 01.
//      Repeat with a match in the same cycle as dismiss_p: ringing stays 0.
//   6. Assert rst_n=0 mid-count at 12:34:56 while ringing: all outputs at reset values
//      asynchronously, alarm=06:00.

Source files
------------

// File: rtl/alarm_clock_timekeeper_pkg.sv
// Shared types and BCD limits for the alarm clock timekeeper.
// bcd_inc() wraps at an arbitrary BCD maximum, so it serves seconds, minutes and hours.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10
  } mode_t;

  localparam logic [7:0] SEC_MAX      = 8'h59;
  localparam logic [7:0] MIN_MAX      = 8'h59;
  localparam logic [7:0] HR_MAX       = 8'h23;
  localparam logic [7:0] ALARM_RST_HH = 8'h06;
  localparam logic [7:0] ALARM_RST_MM = 8'h00;

  // Code 2'b11 is a second encoding of "run".
  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_SET_TIME;
      2'b10:   return MODE_SET_ALARM;
      default: return MODE_RUN;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/alarm_clock_timekeeper_if.sv
// User controls and registered BCD display outputs of the timekeeper.
// The master drives the controls; the slave (the timekeeper) drives the display values.
interface alarm_clock_timekeeper_if;
  logic [1:0] set_mode;
  logic       inc_hr_p;
  logic       inc_min_p;
  logic       alarm_en;
  logic       dismiss_p;
  logic [7:0] time_hh_bcd;
  logic [7:0] time_mm_bcd;
  logic [7:0] time_ss_bcd;
  logic [7:0] alarm_hh_bcd;
  logic [7:0] alarm_mm_bcd;
  logic       tick_1hz;
  logic       alarm_ringing;

  modport master (
    output set_mode, inc_hr_p, inc_min_p, alarm_en, dismiss_p,
    input  time_hh_bcd, time_mm_bcd, time_ss_bcd, alarm_hh_bcd, alarm_mm_bcd,
    input  tick_1hz, alarm_ringing
  );

  modport slave (
    input  set_mode, inc_hr_p, inc_min_p, alarm_en, dismiss_p,
    output time_hh_bcd, time_mm_bcd, time_ss_bcd, alarm_hh_bcd, alarm_mm_bcd,
    output tick_1hz, alarm_ringing
  );
endinterface

// File: rtl/alarm_clock_timekeeper_bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX_BCD; value registered, carry_o combinational.
// clr_i beats inc_i, and a cleared cycle never produces a carry.
module bcd_mod_counter
  import alarm_clock_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = SEC_MAX,
  parameter logic [7:0] RST_BCD = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [7:0] cnt_o,
  output logic       carry_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'h00;
    end else if (inc_i) begin
      cnt_d = bcd_inc(cnt_q, MAX_BCD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_BCD;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign carry_o = inc_i && !clr_i && (cnt_q == MAX_BCD);

endmodule

// File: rtl/alarm_clock_timekeeper.sv
// 24-hour BCD clock with one alarm: prescaler, HH:MM:SS chain, alarm registers, ring timer.
// Time advances on the prescaler wrap edge, so new time and tick_1hz appear together.
module alarm_clock_timekeeper
  import alarm_clock_pkg::*;
#(
  parameter int CLK_HZ    = 10_000_000,
  parameter int RING_SECS = 60
) (
  input logic                     clk,
  input logic                     rst_n,
  alarm_clock_timekeeper_if.slave bus
);

  localparam int             PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [7:0]     RING_LAST = 8'(RING_SECS);

  mode_t         mode;
  logic          set_time, set_alarm, wrap, match;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          ring_q, ring_d;
  logic [7:0]    rcnt_q, rcnt_d;
  logic [7:0]    ss, mm, hh, amm, ahh;
  logic          ss_co, mm_co, hh_co, amm_co, ahh_co;
  logic          mm_inc, hh_inc;
  logic          unused_carries;

  assign mode      = decode_mode(bus.set_mode);
  assign set_time  = (mode == MODE_SET_TIME);
  assign set_alarm = (mode == MODE_SET_ALARM);
  assign wrap      = !set_time && (presc_q == PRESC_MAX);

  // Setting time parks the prescaler at 0, so the first second after release is a full one.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (set_time || wrap) presc_d = '0;
    tick_d = wrap;
  end

  // Set-time pulses bypass the carry chain: minutes never roll into hours while setting.
  assign mm_inc = set_time ? bus.inc_min_p : ss_co;
  assign hh_inc = set_time ? bus.inc_hr_p  : mm_co;

  bcd_mod_counter #(.MAX_BCD(SEC_MAX), .RST_BCD(8'h00)) u_ss (
    .clk(clk), .rst_n(rst_n), .inc_i(wrap), .clr_i(set_time), .cnt_o(ss), .carry_o(ss_co)
  );
  bcd_mod_counter #(.MAX_BCD(MIN_MAX), .RST_BCD(8'h00)) u_mm (
    .clk(clk), .rst_n(rst_n), .inc_i(mm_inc), .clr_i(1'b0), .cnt_o(mm), .carry_o(mm_co)
  );
  bcd_mod_counter #(.MAX_BCD(HR_MAX), .RST_BCD(8'h00)) u_hh (
    .clk(clk), .rst_n(rst_n), .inc_i(hh_inc), .clr_i(1'b0), .cnt_o(hh), .carry_o(hh_co)
  );
  bcd_mod_counter #(.MAX_BCD(MIN_MAX), .RST_BCD(ALARM_RST_MM)) u_amm (
    .clk(clk), .rst_n(rst_n), .inc_i(set_alarm && bus.inc_min_p), .clr_i(1'b0),
    .cnt_o(amm), .carry_o(amm_co)
  );
  bcd_mod_counter #(.MAX_BCD(HR_MAX), .RST_BCD(ALARM_RST_HH)) u_ahh (
    .clk(clk), .rst_n(rst_n), .inc_i(set_alarm && bus.inc_hr_p), .clr_i(1'b0),
    .cnt_o(ahh), .carry_o(ahh_co)
  );

  assign unused_carries = &{1'b0, hh_co, amm_co, ahh_co};

  // Match is evaluated in the tick cycle, when the freshly advanced time is visible.
  always_comb begin
    ring_d = ring_q;
    rcnt_d = rcnt_q;
    match  = tick_q && bus.alarm_en && !set_time && (hh == ahh) && (mm == amm) && (ss == 8'h00);
    if (bus.dismiss_p || !bus.alarm_en || set_time) begin
      ring_d = 1'b0;
    end else if (match) begin
      ring_d = 1'b1;
      rcnt_d = 8'h00;
    end else if (tick_q && ring_q) begin
      rcnt_d = rcnt_q + 8'd1;
      if (rcnt_d == RING_LAST) ring_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      ring_q  <= 1'b0;
      rcnt_q  <= 8'h00;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      ring_q  <= ring_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign bus.time_ss_bcd   = ss;
  assign bus.time_mm_bcd   = mm;
  assign bus.time_hh_bcd   = hh;
  assign bus.alarm_mm_bcd  = amm;
  assign bus.alarm_hh_bcd  = ahh;
  assign bus.tick_1hz      = tick_q;
  assign bus.alarm_ringing = ring_q;

endmodule
